// File: rtl/muldiv_exec_unit_pkg.sv
// Shared constants for the EX-stage mul/div execute unit: MIPS funct codes and engine FSM states.
package alu_pkg;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnSra   = 6'b000011;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  typedef enum logic [1:0] {
    MdIdle,
    MdRun,
    MdDone
  } md_state_e;

endpackage

// File: rtl/muldiv_exec_unit_if.sv
// Issue/result bus between the pipeline (master) and the mul/div execute unit (slave).
interface muldiv_exec_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) ();
  logic            op_valid;
  logic            op_ready;
  logic [5:0]      funct;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            eq;
  logic            ne;
  logic            busy;
  logic            md_done;

  modport master (
    output op_valid, funct, data_a, data_b, shamt,
    input  op_ready, result, result_valid, eq, ne, busy, md_done
  );

  modport slave (
    input  op_valid, funct, data_a, data_b, shamt,
    output op_ready, result, result_valid, eq, ne, busy, md_done
  );
endinterface

// File: rtl/muldiv_iter.sv
// Shared iterative engine: shift-add multiply or restoring divide on unsigned magnitudes,
// one bit per cycle for XLEN cycles, then a single DONE cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CntW = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] p_hi_q, p_lo_q, b_q;
  logic            is_div_q, done_q;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;

  // p_hi/p_lo hold {acc, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {p_hi_q, p_lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, b_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MdIdle;
      cnt_q    <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MdIdle: begin
          if (start_i) begin
            state_q  <= MdRun;
            cnt_q    <= CntW'(XLEN - 1);
            p_hi_q   <= '0;
            p_lo_q   <= op_a_i;
            b_q      <= op_b_i;
            is_div_q <= is_div_i;
          end
        end
        MdRun: begin
          if (is_div_q) begin
            // Borrow out of the trial subtract means restore.
            p_lo_q <= {p_lo_q[XLEN-2:0], ~div_trial[XLEN]};
            p_hi_q <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
          end else begin
            p_hi_q <= mul_sum[XLEN:1];
            p_lo_q <= {mul_sum[0], p_lo_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_q <= MdDone;
            done_q  <= 1'b1;
          end
        end
        MdDone:  state_q <= MdIdle;
        default: state_q <= MdIdle;
      endcase
    end
  end

  assign busy_o = (state_q != MdIdle);
  assign done_o = done_q;
  assign hi_o   = p_hi_q;
  assign lo_o   = p_lo_q;

endmodule

// File: rtl/muldiv_exec_unit.sv
// EX-stage execute unit: single-cycle ALU/shift/MFHI/MFLO plus iterative mul/div into HI/LO.
// Define MULDIV_SIGNED_EN to accept MULT/DIV (magnitude in, sign fix-up when the engine is done).
module muldiv_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic               clk,
  input logic               reset,
  muldiv_exec_unit_if.slave bus
);

  logic              accept, is_md, is_div, is_signed;
  logic              eng_busy, eng_done;
  logic [XLEN-1:0]   alu_res, mag_a, mag_b, eng_hi, eng_lo;
  logic [XLEN-1:0]   hi_q, lo_q, hi_d, lo_d, result_q;
  logic              result_valid_q, neg_a_q, neg_b_q, b_zero_q, md_div_q;
  logic [2*XLEN-1:0] prod_raw, prod;

  assign accept = bus.op_valid && bus.op_ready;

  always_comb begin
    is_md     = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.funct)
      FnMultu: is_md = 1'b1;
      FnDivu: begin
        is_md  = 1'b1;
        is_div = 1'b1;
      end
`ifdef MULDIV_SIGNED_EN
      FnMult: begin
        is_md     = 1'b1;
        is_signed = 1'b1;
      end
      FnDiv: begin
        is_md     = 1'b1;
        is_div    = 1'b1;
        is_signed = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (bus.funct)
      FnAdd:   alu_res = bus.data_a + bus.data_b;
      FnSub:   alu_res = bus.data_a - bus.data_b;
      FnAnd:   alu_res = bus.data_a & bus.data_b;
      FnOr:    alu_res = bus.data_a | bus.data_b;
      FnSlt:   alu_res = XLEN'($signed(bus.data_a) < $signed(bus.data_b));
      FnSll:   alu_res = bus.data_b << bus.shamt;
      FnSrl:   alu_res = bus.data_b >> bus.shamt;
      FnSra:   alu_res = $unsigned($signed(bus.data_b) >>> bus.shamt);
      FnMfhi:  alu_res = hi_q;
      FnMflo:  alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign mag_a = (is_signed && bus.data_a[XLEN-1]) ? -bus.data_a : bus.data_a;
  assign mag_b = (is_signed && bus.data_b[XLEN-1]) ? -bus.data_b : bus.data_b;

  // Divide by zero keeps LO all ones; the remainder already equals |dividend|.
  always_comb begin
    prod_raw = {eng_hi, eng_lo};
    prod     = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
    if (md_div_q) begin
      lo_d = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -eng_lo : eng_lo);
      hi_d = neg_a_q ? -eng_hi : eng_hi;
    end else begin
      hi_d = prod[2*XLEN-1:XLEN];
      lo_d = prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      neg_a_q        <= 1'b0;
      neg_b_q        <= 1'b0;
      b_zero_q       <= 1'b0;
      md_div_q       <= 1'b0;
    end else begin
      result_valid_q <= accept && !is_md;
      if (accept && !is_md) result_q <= alu_res;
      if (accept && is_md) begin
        neg_a_q  <= is_signed && bus.data_a[XLEN-1];
        neg_b_q  <= is_signed && bus.data_b[XLEN-1];
        b_zero_q <= (bus.data_b == '0);
        md_div_q <= is_div;
      end
      if (eng_done) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk_i    (clk),
    .rst_ni   (reset),
    .start_i  (accept && is_md),
    .is_div_i (is_div),
    .op_a_i   (mag_a),
    .op_b_i   (mag_b),
    .busy_o   (eng_busy),
    .done_o   (eng_done),
    .hi_o     (eng_hi),
    .lo_o     (eng_lo)
  );

  assign bus.op_ready     = !eng_busy;
  assign bus.busy         = eng_busy;
  assign bus.md_done      = eng_done;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.eq           = (bus.data_a == bus.data_b);
  assign bus.ne           = (bus.data_a != bus.data_b);

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Bench for muldiv_exec_unit: arithmetic reference model checked every cycle plus directed
// literal checks. MULDIV_SIGNED_EN selects the signed MULT/DIV vectors.
module tb_muldiv_exec_unit;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_exec_unit_if #(.XLEN(XLEN), .SHW(SHW)) bus ();

  muldiv_exec_unit #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model ------------------------------------------------------------------------
  function automatic bit ref_is_md(input logic [5:0] f);
`ifdef MULDIV_SIGNED_EN
    return f == FnMultu || f == FnDivu || f == FnMult || f == FnDiv;
`else
    return f == FnMultu || f == FnDivu;
`endif
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, b,
                                          input logic [4:0] sh, input logic [31:0] hi, lo);
    logic [31:0] r;
    case (f)
      FnAdd:   r = a + b;
      FnSub:   r = a - b;
      FnAnd:   r = a & b;
      FnOr:    r = a | b;
      FnSlt:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FnSll:   r = b << sh;
      FnSrl:   r = b >> sh;
      FnSra:   r = $signed(b) >>> sh;
      FnMfhi:  r = hi;
      FnMflo:  r = lo;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sa, sb;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = int'(a);
    ib = int'(b);
    hi = 32'd0;
    lo = 32'd0;
    if (f == FnMultu) begin
      p  = 64'(a) * 64'(b);
      hi = p[63:32];
      lo = p[31:0];
    end else if (f == FnMult) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (f == FnDivu) begin
      lo = a / b;
      hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = a;
      hi = 32'd0;
    end else begin
      lo = ia / ib;
      hi = ia % ib;
    end
  endfunction

  // m_left: cycles of busy still to come; the cycle with m_left==1 is the md_done cycle.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0, m_res = '0;
  bit          m_rv = 1'b0;
  bit          m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_res  = '0;
      m_rv   = 1'b0;
    end else begin
      m_rdy = (m_left == 0);
      if (m_left == 1) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
      if (m_left > 0) m_left--;
      m_rv = 1'b0;
      if (bus.op_valid && m_rdy) begin
        if (ref_is_md(bus.funct)) begin
          ref_md(bus.funct, bus.data_a, bus.data_b, m_phi, m_plo);
          m_left = XLEN + 1;
        end else begin
          m_res = ref_alu(bus.funct, bus.data_a, bus.data_b, bus.shamt, m_hi, m_lo);
          m_rv  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("op_ready", bus.op_ready, m_left == 0);
      check("busy", bus.busy, m_left > 0);
      check("md_done", bus.md_done, m_left == 1);
      check("result_valid", bus.result_valid, m_rv);
      check("result", bus.result, m_res);
      check("eq", bus.eq, bus.data_a == bus.data_b);
      check("ne", bus.ne, bus.data_a != bus.data_b);
    end
  end

  // Stimulus -------------------------------------------------------------------------------
  task automatic issue(input logic [5:0] f, input logic [31:0] a, b, input logic [4:0] sh);
    bit got;
    got          = 1'b0;
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.data_a   = a;
    bus.data_b   = b;
    bus.shamt    = sh;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.op_ready;
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: funct %b never accepted, want accept within 200 cycles", f);
    end
  endtask

  task automatic op_check(input string name, input logic [5:0] f, input logic [31:0] a, b,
                          input logic [4:0] sh, input logic [31:0] exp);
    issue(f, a, b, sh);
    check({name, "_rv"}, bus.result_valid, 1'b1);
    check(name, bus.result, exp);
  endtask

  task automatic wait_md(input string name, input int exp_lat);
    int cyc;
    cyc = 1;
    while (bus.md_done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_lat"}, cyc, exp_lat);
  endtask

  logic [5:0]  bb_f[3]   = '{FnAdd, FnSub, FnOr};
  logic [31:0] bb_a[3]   = '{32'd1, 32'd10, 32'h0F};
  logic [31:0] bb_b[3]   = '{32'd2, 32'd3, 32'hF0};
  logic [31:0] bb_exp[3] = '{32'd3, 32'd7, 32'hFF};
  int          seen_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.op_valid = 1'b0;
    bus.funct    = '0;
    bus.data_a   = '0;
    bus.data_b   = '0;
    bus.shamt    = '0;
    #12;
    check("rst_result", bus.result, 32'd0);
    check("rst_result_valid", bus.result_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_md_done", bus.md_done, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_rst", bus.op_ready, 1'b1);

    op_check("add_wrap", FnAdd, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
    op_check("sub_wrap", FnSub, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);
    op_check("slt_neg", FnSlt, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    op_check("slt_pos", FnSlt, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0);
    op_check("sra", FnSra, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000);
    op_check("srl", FnSrl, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
    op_check("sll", FnSll, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
    op_check("and", FnAnd, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0);
    op_check("or", FnOr, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFFF0_FFF0);
    op_check("unknown", 6'b111111, 32'd5, 32'd6, 5'd0, 32'd0);
`ifndef MULDIV_SIGNED_EN
    op_check("mult_undef", FnMult, 32'd3, 32'd5, 5'd0, 32'd0);
    op_check("mult_undef_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'd0);
`endif

    // Back-to-back single-cycle issue, one per cycle.
    bus.op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.funct  = bb_f[i];
      bus.data_a = bb_a[i];
      bus.data_b = bb_b[i];
      @(posedge clk);
      #1;
      check("b2b_rv", bus.result_valid, 1'b1);
      check("b2b", bus.result, bb_exp[i]);
    end
    bus.op_valid = 1'b0;

    issue(FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_md("multu", 33);
    op_check("multu_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE);
    op_check("multu_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'h0000_0001);

    issue(FnDivu, 32'd100, 32'd7, 5'd0);
    wait_md("divu", 33);
    op_check("divu_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'd14);
    op_check("divu_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'd2);

    issue(FnDivu, 32'd5, 32'd0, 5'd0);
    wait_md("divu0", 33);
    op_check("divu0_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'd5);
    op_check("divu0_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);

    // MFLO held during busy, with different operands on the bus than the DIVU captured.
    issue(FnDivu, 32'd1000, 32'd3, 5'd0);
    op_check("mflo_held", FnMflo, 32'd12345, 32'd999, 5'd0, 32'd333);
    op_check("mfhi_held", FnMfhi, 32'd0, 32'd0, 5'd0, 32'd1);

    // Reset in the middle of a DIVU.
    issue(FnDivu, 32'd1000, 32'd7, 5'd0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_md_done", bus.md_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.md_done === 1'b1) seen_done++;
    end
    check("midrst_no_done", seen_done, 0);
    op_check("midrst_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'd0);
    op_check("midrst_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'd0);

`ifdef MULDIV_SIGNED_EN
    issue(FnDiv, 32'hFFFF_FFF9, 32'd2, 5'd0);
    wait_md("div", 33);
    op_check("div_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD);
    op_check("div_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    issue(FnMult, 32'hFFFF_FFFD, 32'd5, 5'd0);
    wait_md("mult", 33);
    op_check("mult_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    op_check("mult_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFF1);
    issue(FnDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    wait_md("div_ovf", 33);
    op_check("div_ovf_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'h8000_0000);
    op_check("div_ovf_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'd0);
    issue(FnDiv, 32'hFFFF_FFF9, 32'd0, 5'd0);
    wait_md("div0", 33);
    op_check("div0_hi", FnMfhi, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFF9);
    op_check("div0_lo", FnMflo, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
